// File: rtl/cic_rate_ctrl.sv
// Rate strobes and output sequencer for the single-stage CIC decimator.
// Define CIC_OVR_CNT_EN to add the saturating OVR_CNT overrun counter port.
module cic_rate_ctrl #(
  parameter int CLK_HZ = 24000000,
  parameter int IN_HZ  = 1000000,
  parameter int OUT_HZ = 44100,
  parameter int ACC_W  = 26
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               EN,
  input  logic               CLR,
  output logic               CLKen_in,
  output logic               CLKen_out,
  input  logic signed [15:0] SMPin,
  output logic signed [15:0] SMPout,
  output logic               VALID,
  input  logic               READY,
  output logic               OVERRUN
`ifdef CIC_OVR_CNT_EN
  ,
  output logic [7:0]         OVR_CNT
`endif
);

  localparam logic [ACC_W-1:0] STEP_I = ACC_W'(IN_HZ);
  localparam logic [ACC_W-1:0] STEP_O = ACC_W'(OUT_HZ);
  localparam logic [ACC_W-1:0] LIM    = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_i, acc_o, sum_i, sum_o;
  logic             wrap_i, wrap_o;
  logic             cap_q, prime;
  logic             cap, xfer, ovr;

  // acc < CLK_HZ and STEP < CLK_HZ, so the sum never exceeds ACC_W bits.
  assign sum_i  = acc_i + STEP_I;
  assign sum_o  = acc_o + STEP_O;
  assign wrap_i = (sum_i >= LIM);
  assign wrap_o = (sum_o >= LIM);

  assign cap  = cap_q & EN & prime;
  assign xfer = VALID & READY;
  assign ovr  = cap & VALID & ~xfer;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      acc_i     <= '0;
      acc_o     <= '0;
      CLKen_in  <= 1'b0;
      CLKen_out <= 1'b0;
      cap_q     <= 1'b0;
      prime     <= 1'b0;
    end else if (!EN) begin
      acc_i     <= '0;
      acc_o     <= '0;
      CLKen_in  <= 1'b0;
      CLKen_out <= 1'b0;
      cap_q     <= 1'b0;
      prime     <= 1'b0;
    end else begin
      acc_i     <= wrap_i ? sum_i - LIM : sum_i;
      acc_o     <= wrap_o ? sum_o - LIM : sum_o;
      CLKen_in  <= wrap_i;
      CLKen_out <= wrap_o;
      cap_q     <= CLKen_out;
      // First comb output after enable uses a stale lag register: only arm.
      if (cap_q && !prime) prime <= 1'b1;
    end
  end

  // Output side is not cleared by EN; a held sample can still be drained.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      SMPout  <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (cap) begin
        SMPout <= SMPin;
        VALID  <= 1'b1;
      end else if (xfer) begin
        VALID  <= 1'b0;
      end
      if (ovr)      OVERRUN <= 1'b1;
      else if (CLR) OVERRUN <= 1'b0;
    end
  end

`ifdef CIC_OVR_CNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                 OVR_CNT <= '0;
    else if (ovr && CLR)       OVR_CNT <= 8'd1;
    else if (ovr)              OVR_CNT <= (OVR_CNT == 8'hFF) ? OVR_CNT : OVR_CNT + 8'd1;
    else if (CLR)              OVR_CNT <= '0;
  end
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl: strobe rates/spacing, priming, overrun,
// capture-with-transfer, EN drop/restart and asynchronous reset.
module tb_cic_rate_ctrl;

  logic               CLK = 1'b0;
  logic               RSTn, EN, CLR, READY;
  logic               CLKen_in, CLKen_out, VALID, OVERRUN;
  logic signed [15:0] SMPin, SMPout;
`ifdef CIC_OVR_CNT_EN
  logic [7:0]         ovr_cnt;
`endif

  int ncmp = 0;
  int nerr = 0;

  cic_rate_ctrl dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .EN        (EN),
    .CLR       (CLR),
    .CLKen_in  (CLKen_in),
    .CLKen_out (CLKen_out),
    .SMPin     (SMPin),
    .SMPout    (SMPout),
    .VALID     (VALID),
    .READY     (READY),
    .OVERRUN   (OVERRUN)
`ifdef CIC_OVR_CNT_EN
    ,
    .OVR_CNT   (ovr_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge where CLKen_out is seen high (bounded wait).
  task automatic wait_out(input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CLKen_out && n < 2000);
    chk(tag, {31'd0, CLKen_out}, 32'd1);
  endtask

  task automatic step2();
    @(negedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int cnt_in = 0, cnt_out = 0, first_in = 0, first_out = 0;
    int last_in = 0, last_out = 0, bad_in = 0, bad_out = 0, wide = 0;
    int first_v = 0, vdrop = -1, strb = 0, re_in = 0;
    logic prev_in = 1'b0, prev_out = 1'b0;
    logic [15:0] smp_v = '0;

    RSTn = 1'b0; EN = 1'b0; CLR = 1'b0; READY = 1'b1; SMPin = 16'sh1234;
    repeat (3) @(negedge CLK);
    chk("rst_clken_in",  {31'd0, CLKen_in},  32'd0);
    chk("rst_clken_out", {31'd0, CLKen_out}, 32'd0);
    chk("rst_valid",     {31'd0, VALID},     32'd0);
    chk("rst_overrun",   {31'd0, OVERRUN},   32'd0);
    chk("rst_smpout",    {16'd0, SMPout},    32'd0);
`ifdef CIC_OVR_CNT_EN
    chk("rst_ovr_cnt",   {24'd0, ovr_cnt},   32'd0);
`endif
    RSTn = 1'b1;
    @(negedge CLK);
    EN = 1'b1;

    // Sample k is taken after the k-th enabled edge.
    for (int k = 1; k <= 48000; k++) begin
      @(negedge CLK);
      if (CLKen_in) begin
        cnt_in++;
        if (first_in == 0) first_in = k;
        else if (k - last_in != 24) bad_in++;
        last_in = k;
        if (prev_in) wide++;
      end
      if (CLKen_out) begin
        cnt_out++;
        if (first_out == 0) first_out = k;
        else if (k - last_out != 544 && k - last_out != 545) bad_out++;
        last_out = k;
        if (prev_out) wide++;
      end
      prev_in  = CLKen_in;
      prev_out = CLKen_out;
      if (first_v != 0 && k == first_v + 1) vdrop = int'(VALID);
      if (VALID && first_v == 0) begin
        first_v = k;
        smp_v   = SMPout;
      end
    end
    chk("in_count",     cnt_in,    2000);
    chk("out_count",    cnt_out,   88);
    chk("in_first",     first_in,  24);
    chk("out_first",    first_out, 545);
    chk("in_spacing",   bad_in,    0);
    chk("out_spacing",  bad_out,   0);
    chk("pulse_width",  wide,      0);
    chk("prime_valid_k", first_v,  1091);
    chk("prime_smpout", {16'd0, smp_v}, 32'h1234);
    chk("prime_vdrop",  vdrop,     0);
    chk("run_overrun",  {31'd0, OVERRUN}, 32'd0);

    // Two captures with no consumer: second overwrites and flags overrun.
    READY = 1'b0; SMPin = 16'sh0100;
    wait_out("ovr_wait1");
    step2();
    chk("ovr_valid1",  {31'd0, VALID},   32'd1);
    chk("ovr_smp1",    {16'd0, SMPout},  32'h0100);
    chk("ovr_flag0",   {31'd0, OVERRUN}, 32'd0);
    SMPin = 16'sh0200;
    wait_out("ovr_wait2");
    step2();
    chk("ovr_smp2",    {16'd0, SMPout},  32'h0200);
    chk("ovr_flag1",   {31'd0, OVERRUN}, 32'd1);
`ifdef CIC_OVR_CNT_EN
    chk("ovr_cnt1",    {24'd0, ovr_cnt}, 32'd1);
`endif
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_overrun", {31'd0, OVERRUN}, 32'd0);
`ifdef CIC_OVR_CNT_EN
    chk("clr_ovr_cnt", {24'd0, ovr_cnt}, 32'd0);
`endif

    // Capture coincides with a transfer of the held sample.
    SMPin = 16'sh0300;
    wait_out("xfer_wait");
    @(negedge CLK);
    READY = 1'b1;
    @(negedge CLK);
    chk("xfer_valid",   {31'd0, VALID},   32'd1);
    chk("xfer_smp",     {16'd0, SMPout},  32'h0300);
    chk("xfer_overrun", {31'd0, OVERRUN}, 32'd0);
    @(negedge CLK);
    chk("xfer_drain",   {31'd0, VALID},   32'd0);

    // EN drop right after a CLKen_out: pending capture must be suppressed.
    READY = 1'b0; SMPin = 16'sh0400;
    wait_out("en_wait");
    EN = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (CLKen_in || CLKen_out) strb++;
    end
    chk("en_off_strobes", strb, 0);
    chk("en_off_valid",   {31'd0, VALID}, 32'd0);
    EN = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (CLKen_in && re_in == 0) re_in = i;
    end
    chk("reen_first_in", re_in, 24);
    wait_out("reen_wait1");
    step2();
    chk("reen_discard", {31'd0, VALID}, 32'd0);
    SMPin = 16'sh0500;
    wait_out("reen_wait2");
    step2();
    chk("reen_valid",   {31'd0, VALID},  32'd1);
    chk("reen_smp",     {16'd0, SMPout}, 32'h0500);
    SMPin = 16'sh0600;
    wait_out("reen_wait3");
    step2();
    chk("reen_overrun", {31'd0, OVERRUN}, 32'd1);
    chk("reen_smp2",    {16'd0, SMPout},  32'h0600);

    // Asynchronous reset between edges.
    @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_valid",   {31'd0, VALID},     32'd0);
    chk("arst_overrun", {31'd0, OVERRUN},   32'd0);
    chk("arst_smpout",  {16'd0, SMPout},    32'd0);
    chk("arst_strobes", {30'd0, CLKen_in, CLKen_out}, 32'd0);
`ifdef CIC_OVR_CNT_EN
    chk("arst_ovr_cnt", {24'd0, ovr_cnt},   32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
